// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, both on operand magnitudes,
// one bit per cycle, with the sign applied to the final 2*XLEN / XLEN result.
// Optional divider: define MDU_DIV_EN to build it. Without it, divide ops
// complete immediately with result 0.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic            cpu_clk,
    input  logic            cpu_rst,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [1:0]      op_q;     // low funct3 bits: result selection
    logic            neg_q;    // product / quotient must be negated
    logic [XLEN-1:0] hi_q;     // partial product high half / partial remainder
    logic [XLEN-1:0] lo_q;     // multiplier bits / dividend-then-quotient bits
    logic [XLEN-1:0] b_q;      // multiplicand / divisor magnitude

    // operand sign handling at accept time
    logic            a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0] a_mag, b_mag;

    // next iteration values and final result
    logic [XLEN:0]     mul_sum;
    logic [XLEN-1:0]   nxt_hi, nxt_lo, fin;
    logic [2*XLEN-1:0] prod, prod_s;

`ifdef MDU_DIV_EN
    logic            div_q;    // operation in flight is a divide
    logic            rneg_q;   // remainder must be negated (dividend sign)
    logic            ovf;      // most-negative / -1 special case
    logic [XLEN:0]   rem_sh;
    logic [XLEN+1:0] diff;
    logic            ge;
    logic [XLEN-1:0] div_hi, div_lo, fin_div;
`endif

    // decode operand signedness and take magnitudes
    always_comb begin
        a_sgn = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
        b_sgn = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
        a_neg = a_sgn && src_a[XLEN-1];
        b_neg = b_sgn && src_b[XLEN-1];
        a_mag = a_neg ? -src_a : src_a;
        b_mag = b_neg ? -src_b : src_b;
    end

    // one datapath step plus sign correction of the completed value
    always_comb begin
        // multiply: add multiplicand when the current multiplier bit is set, shift right
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        nxt_hi  = mul_sum[XLEN:1];
        nxt_lo  = {mul_sum[0], lo_q[XLEN-1:1]};
`ifdef MDU_DIV_EN
        ovf     = (op[2] && !op[0]) && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&src_b);
        // restoring divide: shift in next dividend bit, subtract if it fits
        rem_sh  = {hi_q, lo_q[XLEN-1]};
        diff    = {1'b0, rem_sh} - {2'b00, b_q};
        ge      = !diff[XLEN+1];
        div_hi  = ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0];
        div_lo  = {lo_q[XLEN-2:0], ge};
        if (div_q) begin
            nxt_hi = div_hi;
            nxt_lo = div_lo;
        end
`endif
        prod   = {nxt_hi, nxt_lo};
        prod_s = neg_q ? -prod : prod;
        fin    = (op_q == 2'b00) ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`ifdef MDU_DIV_EN
        fin_div = op_q[1] ? (rneg_q ? -nxt_hi : nxt_hi)
                          : (neg_q  ? -nxt_lo : nxt_lo);
        if (div_q) fin = fin_div;
`endif
    end

    // control FSM with registered busy/done/result; flush beats everything
    always_ff @(posedge cpu_clk or negedge cpu_rst) begin
        if (!cpu_rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            neg_q  <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
`ifdef MDU_DIV_EN
            div_q  <= 1'b0;
            rneg_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            if (flush) begin
                state <= IDLE;
                busy  <= 1'b0;
                cnt   <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            op_q  <= op[1:0];
                            neg_q <= a_neg ^ b_neg;
                            hi_q  <= '0;
                            lo_q  <= a_mag;
                            b_q   <= b_mag;
                            cnt   <= '0;
                            busy  <= 1'b1;
`ifdef MDU_DIV_EN
                            div_q  <= op[2];
                            rneg_q <= a_neg;
                            if (op[2] && (src_b == '0)) begin
                                result <= op[1] ? src_a : '1;
                                state  <= DONE;
                                done   <= 1'b1;
                            end else if (ovf) begin
                                result <= op[1] ? '0 : src_a;
                                state  <= DONE;
                                done   <= 1'b1;
                            end else begin
                                state <= CALC;
                            end
`else
                            if (op[2]) begin
                                result <= '0;
                                state  <= DONE;
                                done   <= 1'b1;
                            end else begin
                                state <= CALC;
                            end
`endif
                        end
                    end
                    CALC: begin
                        hi_q <= nxt_hi;
                        lo_q <= nxt_lo;
                        cnt  <= cnt + CW'(1);
                        if (cnt == CW'(XLEN-1)) begin
                            result <= fin;
                            state  <= DONE;
                            done   <= 1'b1;
                        end
                    end
                    DONE: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: randomized + directed self-checking bench for mul_div_unit.
// Reference model uses plain 64-bit arithmetic; follows MDU_DIV_EN like the DUT.
module tb_mul_div_unit;
    localparam int XLEN = 32;

    logic            clk, rst_n, start, flush;
    logic [2:0]      op;
    logic [XLEN-1:0] src_a, src_b;
    logic            busy, done;
    logic [XLEN-1:0] result;

    int total = 0;
    int bad   = 0;
    logic [XLEN-1:0] last_res;

    mul_div_unit #(.XLEN(XLEN)) dut (
        .cpu_clk(clk), .cpu_rst(rst_n), .start(start), .op(op),
        .src_a(src_a), .src_b(src_b), .flush(flush),
        .busy(busy), .done(done), .result(result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // RV32M semantics straight from the ISA rules
    function automatic logic [XLEN-1:0] model(input logic [2:0] o, input logic [XLEN-1:0] a,
                                              input logic [XLEN-1:0] b);
        longint sa, sb, ub;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        case (o)
            3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            default: begin
`ifdef MDU_DIV_EN
                if (b == 0) return o[1] ? a : 32'hFFFF_FFFF;
                if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'h0 : a;
                case (o)
                    3'd4:    return 32'(sa / sb);
                    3'd5:    return a / b;
                    3'd6:    return 32'(sa % sb);
                    default: return a % b;
                endcase
`else
                return 32'h0;
`endif
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [XLEN-1:0] a,
                                     input logic [XLEN-1:0] b);
        if (!o[2]) return XLEN;
`ifdef MDU_DIV_EN
        if (b == 0) return 0;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return XLEN;
`else
        return 0;
`endif
    endfunction

    // called at a negedge; start at the next edge E0, wait for done, check all
    task automatic run_op(input logic [2:0] o, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                          input string tag);
        int lat;
        logic seen;
        logic [XLEN-1:0] exp;
        exp = model(o, a, b);
        start = 1'b1; op = o; src_a = a; src_b = b;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        src_a = $urandom; src_b = $urandom;
        lat = 0; seen = 1'b0;
        for (int i = 0; i < XLEN + 4 && !seen; i++) begin
            if (done) seen = 1'b1;
            else begin
                start = 1'($urandom_range(0, 1));
                op    = 3'($urandom);
                @(negedge clk);
                lat++;
            end
        end
        start = 1'b0;
        if (!seen) chk({tag, " timeout"}, 0, 1);
        else begin
            chk({tag, " latency"}, 64'(lat), 64'(model_lat(o, a, b)));
            chk({tag, " result"}, result, exp);
            chk({tag, " busy@done"}, busy, 1);
        end
        last_res = exp;
        @(negedge clk);
        chk({tag, " done pulse"}, {busy, done}, 2'b00);
    endtask

    logic [XLEN-1:0] specials [5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

    function automatic logic [XLEN-1:0] pick();
        if ($urandom_range(0, 3) == 0) return specials[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    initial begin
        int dones;
        rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 3'd0; src_a = '0; src_b = '0;
        last_res = '0;
        #1;
        chk("reset busy", busy, 0);
        chk("reset done", done, 0);
        chk("reset result", result, 0);
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;

        // directed cases
        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, "mul");
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu");
        run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh");
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, "mulhsu");
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, "div");
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, "rem");
        run_op(3'd5, 32'd5, 32'd0, "divu0");
        run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem ovf");
        run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div ovf");
        run_op(3'd4, 32'd10, 32'd3, "div10/3");
        run_op(3'd0, 32'd6, 32'd7, "mul6*7");

        // randomized against the model
        for (int n = 0; n < 60; n++) run_op(3'($urandom), pick(), pick(), "rand");

        // flush at E10 of a multiply
        start = 1'b1; op = 3'd0; src_a = 32'd1234; src_b = 32'd5678;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 9; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("flush busy", busy, 0);
        chk("flush done", done, 0);
        chk("flush result", result, last_res);
        @(negedge clk);
        chk("flush no done", done, 0);
        run_op(3'd0, 32'd1234, 32'd5678, "after flush");

        // flush on the final CALC edge wins over CALC->DONE
        start = 1'b1; op = 3'd3; src_a = $urandom; src_b = $urandom;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < XLEN - 1; i++) @(negedge clk);
        flush = 1'b1;
        @(negedge clk); flush = 1'b0;
        chk("late flush done", {busy, done}, 2'b00);
        chk("late flush result", result, last_res);

        // flush beats start in IDLE
        start = 1'b1; flush = 1'b1; op = 3'd0;
        @(negedge clk); start = 1'b0; flush = 1'b0;
        chk("flush vs start", busy, 0);

        // async reset mid-CALC
        start = 1'b1; op = 3'd0; src_a = 32'hDEAD_BEEF; src_b = 32'h1357_9BDF;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        for (int i = 0; i < 5; i++) @(negedge clk);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk("arst busy", busy, 0);
        chk("arst done", done, 0);
        chk("arst result", result, 0);
        @(negedge clk); rst_n = 1'b1;
        dones = 0;
        for (int i = 0; i < XLEN + 8; i++) begin
            @(negedge clk);
            if (done) dones++;
        end
        chk("no done after reset", 64'(dones), 0);
        run_op(3'd1, 32'h8000_0000, 32'h8000_0000, "post reset");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
